// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer_if
//  Description : Bundle of the command, ALU issue and response channels of
//                the ALU command sequencer.
//                  cmd_* : execute dispatch -> sequencer (valid/ready)
//                  alu_* : sequencer <-> ALU (start pulse, operands, result)
//                  rsp_* : sequencer -> consumer (valid/ready, tag, status)
//                master : the sequencer's view (drives cmd_ready, alu_start,
//                         alu operands and the response channel).
//                slave  : the surrounding system's view (dispatch, ALU,
//                         response consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_rs1_signed;
    logic             cmd_rs2_signed;
    logic [3:0]       cmd_tag;

    logic             alu_start;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_rs1_signed;
    logic             alu_rs2_signed;
    logic             alu_valid;
    logic             alu_error;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_tag;
    logic [1:0]       rsp_status;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rs1_signed, cmd_rs2_signed, cmd_tag,
        output cmd_ready,
        output alu_start, alu_op, alu_a, alu_b, alu_rs1_signed, alu_rs2_signed,
        input  alu_valid, alu_error, alu_result,
        output rsp_valid, rsp_result, rsp_tag, rsp_status,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rs1_signed, cmd_rs2_signed, cmd_tag,
        input  cmd_ready,
        input  alu_start, alu_op, alu_a, alu_b, alu_rs1_signed, alu_rs2_signed,
        output alu_valid, alu_error, alu_result,
        input  rsp_valid, rsp_result, rsp_tag, rsp_status,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Command front-end for the integer/IEEE-754 ALU. Buffers
//                requests in a DEPTH-entry FIFO, issues one at a time with a
//                single-cycle alu_start, waits a fixed latency (simple ops) or
//                for alu_valid / timeout (multicycle ops), and returns a
//                tagged result with status on a valid/ready channel.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - alu_cmd_sequencer_if.master (cmd/alu/rsp channels)
//  Status      : 00 ok, 01 ALU error, 10 timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int LAT_SIMPLE = 2,
    parameter int TIMEOUT    = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    alu_cmd_sequencer_if.master    bus
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_ENT_W   = 5 + 2 * WIDTH + 2 + 4;
    localparam int c_CNT_MAX = (LAT_SIMPLE > TIMEOUT) ? LAT_SIMPLE : TIMEOUT;
    localparam int c_WCNT_W  = $clog2(c_CNT_MAX + 1);

    localparam logic [c_PTR_W:0]    c_FULL     = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]    c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_WCNT_W-1:0] c_LAT_LAST = c_WCNT_W'(LAT_SIMPLE - 1);
    localparam logic [c_WCNT_W-1:0] c_TO_LAST  = c_WCNT_W'(TIMEOUT - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE = c_WCNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_nxt;
    logic               r_cmd_ready;
    logic               w_push;
    logic               w_pop;

    logic [4:0]         w_h_op;
    logic [WIDTH-1:0]   w_h_a;
    logic [WIDTH-1:0]   w_h_b;
    logic               w_h_s1;
    logic               w_h_s2;
    logic [3:0]         w_h_tag;

    assign w_push        = bus.cmd_valid && r_cmd_ready;
    assign bus.cmd_ready = r_cmd_ready;
    assign {w_h_op, w_h_a, w_h_b, w_h_s1, w_h_s2, w_h_tag} = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b,
                                bus.cmd_rs1_signed, bus.cmd_rs2_signed, bus.cmd_tag};
        end
    end

    // Ready is registered from the next count, so it tracks !full of the
    // registered count and is held low for the cycle after any reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != c_FULL);
        end
    end

    // ------------------------------------------------------- issue registers
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_s1;
    logic               r_s2;
    logic [3:0]         r_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_tag <= '0;
        end else if (w_pop) begin
            r_op  <= w_h_op;
            r_a   <= w_h_a;
            r_b   <= w_h_b;
            r_s1  <= w_h_s1;
            r_s2  <= w_h_s2;
            r_tag <= w_h_tag;
        end
    end

    assign bus.alu_op         = r_op;
    assign bus.alu_a          = r_a;
    assign bus.alu_b          = r_b;
    assign bus.alu_rs1_signed = r_s1;
    assign bus.alu_rs2_signed = r_s2;

    // MAC with both operands zero is the accumulator clear, a one-cycle op.
    logic w_multi;
    always_comb begin
        w_multi = 1'b0;
        case (r_op)
            5'd8, 5'd9, 5'd10, 5'd11: w_multi = 1'b1;
            5'd14:                    w_multi = (r_a != '0) || (r_b != '0);
            default:                  w_multi = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_err_seen;
    logic                w_capture;
    logic [WIDTH-1:0]    w_cap_result;
    logic [1:0]          w_cap_status;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_cap_result = '0;
        w_cap_status = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_multi) begin
                    if (r_wcnt == c_LAT_LAST) begin
                        w_capture    = 1'b1;
                        w_cap_result = bus.alu_result;
                    end
                end else if (bus.alu_valid) begin
                    // A completion beats a timeout landing in the same cycle.
                    w_capture    = 1'b1;
                    w_cap_result = bus.alu_result;
                    w_cap_status = (bus.alu_error || r_err_seen) ? 2'b01 : 2'b00;
                end else if (r_wcnt == c_TO_LAST) begin
                    w_capture    = 1'b1;
                    w_cap_status = 2'b10;
                end
                if (w_capture) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait counter never wraps: WAIT is left at LAT_SIMPLE-1 or TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_err_seen <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)     r_wcnt <= '0;
            else if (r_state == S_WAIT) r_wcnt <= r_wcnt + c_WCNT_ONE;

            if (w_pop) begin
                r_err_seen <= 1'b0;
            end else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && bus.alu_error) begin
                r_err_seen <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- response
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_tag;
    logic [1:0]       r_rsp_status;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_status <= 2'b00;
        end else if (w_capture) begin
            r_rsp_result <= w_cap_result;
            r_rsp_tag    <= r_tag;
            r_rsp_status <= w_cap_status;
        end
    end

    assign bus.alu_start  = (r_state == S_ISSUE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.rsp_status = r_rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Directed self-checking bench for alu_cmd_sequencer
//                (WIDTH=32, DEPTH=4, LAT_SIMPLE=2, TIMEOUT=8). The bench
//                plays dispatch, ALU and response consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 4;
    localparam int LAT_SIMPLE = 2;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH)) u_if ();

    alu_cmd_sequencer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .LAT_SIMPLE (LAT_SIMPLE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        u_if.cmd_valid      = 1'b1;
        u_if.cmd_op         = op;
        u_if.cmd_a          = a;
        u_if.cmd_b          = b;
        u_if.cmd_rs1_signed = 1'b0;
        u_if.cmd_rs2_signed = 1'b1;
        u_if.cmd_tag        = tag;
    endtask

    task automatic ack();
        u_if.rsp_ready = 1'b1;
        tick();
        u_if.rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input int max, input string tag);
        int i = 0;
        while (!u_if.rsp_valid && i < max) begin
            tick();
            i++;
        end
        chk(tag, 64'(u_if.rsp_valid), 64'd1);
    endtask

    logic [3:0] exp_tags [5];
    logic       seen;

    initial begin
        rst                 = 1'b1;
        u_if.cmd_valid      = 1'b0;
        u_if.cmd_op         = '0;
        u_if.cmd_a          = '0;
        u_if.cmd_b          = '0;
        u_if.cmd_rs1_signed = 1'b0;
        u_if.cmd_rs2_signed = 1'b0;
        u_if.cmd_tag        = '0;
        u_if.alu_valid      = 1'b0;
        u_if.alu_error      = 1'b0;
        u_if.alu_result     = '0;
        u_if.rsp_ready      = 1'b0;
        exp_tags            = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

        // ---- reset values
        repeat (3) tick();
        chk("rst_cmd_ready",  64'(u_if.cmd_ready),  64'd0);
        chk("rst_alu_start",  64'(u_if.alu_start),  64'd0);
        chk("rst_alu_op",     64'(u_if.alu_op),     64'd0);
        chk("rst_alu_a",      64'(u_if.alu_a),      64'd0);
        chk("rst_rsp_valid",  64'(u_if.rsp_valid),  64'd0);
        chk("rst_rsp_result", 64'(u_if.rsp_result), 64'd0);
        chk("rst_rsp_tag",    64'(u_if.rsp_tag),    64'd0);
        chk("rst_rsp_status", 64'(u_if.rsp_status), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_rel_ready",  64'(u_if.cmd_ready),  64'd1);

        // ---- simple add: issue at cycle 2, result sampled end of cycle 4
        offer(5'd6, 32'd5, 32'd7, 4'd3);
        tick();                                    // cycle 1
        u_if.cmd_valid = 1'b0;
        chk("t1_start_c1", 64'(u_if.alu_start), 64'd0);
        tick();                                    // cycle 2
        chk("t1_start_c2", 64'(u_if.alu_start), 64'd1);
        chk("t1_alu_op",   64'(u_if.alu_op),    64'd6);
        chk("t1_alu_a",    64'(u_if.alu_a),     64'd5);
        chk("t1_alu_b",    64'(u_if.alu_b),     64'd7);
        chk("t1_alu_s2",   64'(u_if.alu_rs2_signed), 64'd1);
        tick();                                    // cycle 3
        u_if.alu_result = 32'd99;
        chk("t1_start_c3", 64'(u_if.alu_start), 64'd0);
        chk("t1_rsp_c3",   64'(u_if.rsp_valid), 64'd0);
        tick();                                    // cycle 4
        u_if.alu_result = 32'd12;
        chk("t1_rsp_c4",   64'(u_if.rsp_valid), 64'd0);
        tick();                                    // cycle 5
        u_if.alu_result = 32'd0;
        chk("t1_rsp_c5",   64'(u_if.rsp_valid),  64'd1);
        chk("t1_result",   64'(u_if.rsp_result), 64'd12);
        chk("t1_tag",      64'(u_if.rsp_tag),    64'd3);
        chk("t1_status",   64'(u_if.rsp_status), 64'd0);
        tick();
        chk("t1_hold",     64'(u_if.rsp_valid),  64'd1);
        ack();
        chk("t1_released", 64'(u_if.rsp_valid),  64'd0);

        // ---- fill the FIFO while stalled in RESP
        offer(5'd6, 32'd1, 32'd1, 4'd1);
        tick();
        u_if.cmd_valid = 1'b0;
        wait_rsp(10, "t2_first_rsp");
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_before_push", 64'(u_if.cmd_ready), 64'd1);
            offer(5'd6, 32'd1, 32'd1, 4'(2 + i));
            tick();
        end
        u_if.cmd_valid = 1'b0;
        chk("t2_full", 64'(u_if.cmd_ready), 64'd0);
        offer(5'd6, 32'd1, 32'd1, 4'd9);
        tick();
        tick();
        u_if.cmd_valid = 1'b0;
        chk("t2_refused", 64'(u_if.cmd_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(10, "t2_drain_rsp");
            chk("t2_drain_tag", 64'(u_if.rsp_tag), 64'(exp_tags[i]));
            ack();
        end
        repeat (5) tick();
        chk("t2_no_extra", 64'(u_if.rsp_valid), 64'd0);
        chk("t2_ready_empty", 64'(u_if.cmd_ready), 64'd1);

        // ---- divide by zero: error at T+3, valid at T+5 -> rsp at T+6, 01
        offer(5'd10, 32'd100, 32'd0, 4'd7);
        tick();
        u_if.cmd_valid = 1'b0;
        tick();                                    // T
        chk("t3_start", 64'(u_if.alu_start), 64'd1);
        chk("t3_op",    64'(u_if.alu_op),    64'd10);
        tick();                                    // T+1
        tick();                                    // T+2
        tick();                                    // T+3
        u_if.alu_error = 1'b1;
        tick();                                    // T+4
        u_if.alu_error = 1'b0;
        chk("t3_rsp_t4", 64'(u_if.rsp_valid), 64'd0);
        tick();                                    // T+5
        u_if.alu_valid  = 1'b1;
        u_if.alu_result = 32'hDEAD_0001;
        chk("t3_rsp_t5", 64'(u_if.rsp_valid), 64'd0);
        tick();                                    // T+6
        u_if.alu_valid = 1'b0;
        chk("t3_rsp_t6", 64'(u_if.rsp_valid),  64'd1);
        chk("t3_status", 64'(u_if.rsp_status), 64'd1);
        chk("t3_result", 64'(u_if.rsp_result), 64'hDEAD_0001);
        chk("t3_tag",    64'(u_if.rsp_tag),    64'd7);
        chk("t3_op_stable", 64'(u_if.alu_op),  64'd10);
        ack();

        // ---- exp timeout (TIMEOUT=8) -> rsp at T+9, then next command issues
        u_if.alu_result = 32'h55;
        offer(5'd9, 32'd3, 32'd4, 4'd8);
        tick();                                    // cycle 1
        offer(5'd6, 32'd1, 32'd2, 4'd9);
        tick();                                    // T
        u_if.cmd_valid = 1'b0;
        chk("t4_start", 64'(u_if.alu_start), 64'd1);
        chk("t4_op",    64'(u_if.alu_op),    64'd9);
        repeat (8) tick();                         // T+8
        chk("t4_rsp_t8", 64'(u_if.rsp_valid), 64'd0);
        tick();                                    // T+9 = R
        chk("t4_rsp_t9", 64'(u_if.rsp_valid),  64'd1);
        chk("t4_result", 64'(u_if.rsp_result), 64'd0);
        chk("t4_status", 64'(u_if.rsp_status), 64'd2);
        chk("t4_tag",    64'(u_if.rsp_tag),    64'd8);
        ack();                                     // R+1
        chk("t4_start_r1", 64'(u_if.alu_start), 64'd0);
        tick();                                    // R+2
        chk("t4_start_r2", 64'(u_if.alu_start), 64'd1);
        chk("t4_next_op",  64'(u_if.alu_op),    64'd6);
        repeat (3) tick();                         // R+5
        chk("t4_next_rsp",    64'(u_if.rsp_valid),  64'd1);
        chk("t4_next_tag",    64'(u_if.rsp_tag),    64'd9);
        chk("t4_next_status", 64'(u_if.rsp_status), 64'd0);
        chk("t4_next_result", 64'(u_if.rsp_result), 64'h55);
        ack();

        // ---- MAC clear is simple; MAC with operands waits for alu_valid
        offer(5'd14, 32'd0, 32'd0, 4'd10);
        tick();
        u_if.cmd_valid = 1'b0;
        tick();                                    // T
        chk("t5_clr_start", 64'(u_if.alu_start), 64'd1);
        repeat (3) tick();                         // T+3
        chk("t5_clr_rsp",    64'(u_if.rsp_valid),  64'd1);
        chk("t5_clr_tag",    64'(u_if.rsp_tag),    64'd10);
        chk("t5_clr_status", 64'(u_if.rsp_status), 64'd0);
        ack();
        offer(5'd14, 32'd2, 32'd3, 4'd11);
        tick();
        u_if.cmd_valid = 1'b0;
        tick();                                    // T
        chk("t5_mac_start", 64'(u_if.alu_start), 64'd1);
        repeat (3) tick();                         // T+3
        chk("t5_mac_wait_t3", 64'(u_if.rsp_valid), 64'd0);
        tick();                                    // T+4
        chk("t5_mac_wait_t4", 64'(u_if.rsp_valid), 64'd0);
        u_if.alu_valid  = 1'b1;
        u_if.alu_result = 32'd77;
        tick();                                    // T+5
        u_if.alu_valid = 1'b0;
        chk("t5_mac_rsp",    64'(u_if.rsp_valid),  64'd1);
        chk("t5_mac_result", 64'(u_if.rsp_result), 64'd77);
        chk("t5_mac_tag",    64'(u_if.rsp_tag),    64'd11);
        ack();

        // ---- reset during WAIT with two commands queued
        offer(5'd10, 32'd8, 32'd2, 4'd1);
        tick();                                    // cycle 1
        offer(5'd6, 32'd1, 32'd1, 4'd2);
        tick();                                    // cycle 2
        offer(5'd6, 32'd1, 32'd1, 4'd3);
        tick();                                    // cycle 3 (WAIT)
        u_if.cmd_valid = 1'b0;
        tick();                                    // cycle 4
        rst = 1'b1;
        tick();                                    // cycle 5
        chk("t6_rst_ready", 64'(u_if.cmd_ready), 64'd0);
        chk("t6_rst_rsp",   64'(u_if.rsp_valid), 64'd0);
        chk("t6_rst_start", 64'(u_if.alu_start), 64'd0);
        chk("t6_rst_op",    64'(u_if.alu_op),    64'd0);
        rst = 1'b0;
        tick();                                    // cycle 6
        chk("t6_ready_back", 64'(u_if.cmd_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            u_if.alu_valid = (i == 3);
            seen = seen | u_if.rsp_valid | u_if.alu_start;
            tick();
        end
        u_if.alu_valid = 1'b0;
        chk("t6_quiet", 64'(seen), 64'd0);

        // ---- normal operation after reset
        u_if.alu_result = 32'd42;
        offer(5'd6, 32'd20, 32'd22, 4'd12);
        tick();
        u_if.cmd_valid = 1'b0;
        wait_rsp(10, "t7_rsp");
        chk("t7_tag",    64'(u_if.rsp_tag),    64'd12);
        chk("t7_result", 64'(u_if.rsp_result), 64'd42);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
